// File: rtl/gpio_port.sv
// Memory-mapped GPIO peripheral for the mips data bus: synchronised and debounced
// inputs, atomic set/clear outputs, and edge capture with a level interrupt.
module gpio_port #(
   parameter int unsigned            WIDTH     = 8,
   parameter int unsigned            DEBOUNCE  = 4,
   parameter logic [WIDTH-1:0]       RESET_OUT = '0
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             cs_i,
   input  logic             we_i,
   input  logic [4:0]       addr_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o,
   input  logic [WIDTH-1:0] GPIO_i,
   output logic [WIDTH-1:0] GPIO_o,
   output logic             irq_o
);

   localparam logic [2:0] A_DATA_IN  = 3'd0;
   localparam logic [2:0] A_DATA_OUT = 3'd1;
   localparam logic [2:0] A_OUT_SET  = 3'd2;
   localparam logic [2:0] A_OUT_CLR  = 3'd3;
   localparam logic [2:0] A_RISE_EN  = 3'd4;
   localparam logic [2:0] A_FALL_EN  = 3'd5;
   localparam logic [2:0] A_STATUS   = 3'd6;

   localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE - 1);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_deb;
   logic [7:0]       r_cnt [WIDTH];
   logic [WIDTH-1:0] r_data_out;
   logic [WIDTH-1:0] r_rise_en;
   logic [WIDTH-1:0] r_fall_en;
   logic [WIDTH-1:0] r_status;

   logic [WIDTH-1:0] w_deb_next;
   logic [7:0]       w_cnt_next [WIDTH];
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_w1c;
   logic [WIDTH-1:0] w_wdata;
   logic [2:0]       w_word;
   logic             w_wr;
   logic [31:0]      w_rdata;
   logic             w_unused;

   assign w_word   = addr_i[4:2];
   assign w_wdata  = wdata_i[WIDTH-1:0];
   assign w_wr     = cs_i & we_i;
   assign w_unused = ^{addr_i[1:0], wdata_i[31:WIDTH]};

   // A bit commits only after sync2 has disagreed with deb for DEBOUNCE cycles.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_deb_next = r_deb;
      for (int i = 0; i < int'(WIDTH); i++) begin
         w_cnt_next[i] = '0;
         if (r_sync2[i] != r_deb[i]) begin
            if (r_cnt[i] == DEB_LAST) w_deb_next[i] = r_sync2[i];
            else                      w_cnt_next[i] = r_cnt[i] + 8'd1;
         end
      end
   end

   assign w_rise = ~r_deb &  w_deb_next & r_rise_en;
   assign w_fall =  r_deb & ~w_deb_next & r_fall_en;
   assign w_w1c  = (w_wr && w_word == A_STATUS) ? w_wdata : '0;

   // NOTE: the per-bit counters are state, not storage, so they are reset like any flop.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_deb   <= '0;
         for (int i = 0; i < int'(WIDTH); i++) r_cnt[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments keep the sync1 -> sync2 chain a true two-stage shift.
         r_sync1 <= GPIO_i;
         r_sync2 <= r_sync1;
         r_deb   <= w_deb_next;
         for (int i = 0; i < int'(WIDTH); i++) r_cnt[i] <= w_cnt_next[i];
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_data_out <= RESET_OUT;
         r_rise_en  <= '0;
         r_fall_en  <= '0;
         r_status   <= '0;
      end else begin
         if (w_wr) begin
            case (w_word)
               A_DATA_OUT: r_data_out <= w_wdata;
               A_OUT_SET:  r_data_out <= r_data_out | w_wdata;
               A_OUT_CLR:  r_data_out <= r_data_out & ~w_wdata;
               A_RISE_EN:  r_rise_en  <= w_wdata;
               A_FALL_EN:  r_fall_en  <= w_wdata;
               default:    ;
            endcase
         end
         // A fresh edge outranks a simultaneous clear of the same bit.
         r_status <= (r_status & ~w_w1c) | w_rise | w_fall;
      end
   end

   always_comb begin
      w_rdata = '0;
      if (cs_i) begin
         case (w_word)
            A_DATA_IN:  w_rdata = 32'(r_deb);
            A_DATA_OUT: w_rdata = 32'(r_data_out);
            A_RISE_EN:  w_rdata = 32'(r_rise_en);
            A_FALL_EN:  w_rdata = 32'(r_fall_en);
            A_STATUS:   w_rdata = 32'(r_status);
            default:    w_rdata = '0;
         endcase
      end
   end

   assign rdata_o = w_rdata;
   assign GPIO_o  = r_data_out;
   assign irq_o   = |r_status;

endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port (WIDTH=8, DEBOUNCE=4, RESET_OUT=0) with hand-computed
// expectations checked by immediate assertions.
module tb_gpio_port;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        cs_i;
   logic        we_i;
   logic [4:0]  addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic [7:0]  GPIO_i;
   logic [7:0]  GPIO_o;
   logic        irq_o;

   int n_vec = 0;
   int n_err = 0;

   gpio_port #(.WIDTH(8), .DEBOUNCE(4), .RESET_OUT(8'h00)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .cs_i    (cs_i),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .rdata_o (rdata_o),
      .GPIO_i  (GPIO_i),
      .GPIO_o  (GPIO_o),
      .irq_o   (irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Combinational read, done mid-cycle away from any clock edge.
   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      cs_i   = 1'b1;
      we_i   = 1'b0;
      addr_i = a;
      #1;
      d      = rdata_o;
      cs_i   = 1'b0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      cs_i    = 1'b1;
      we_i    = 1'b1;
      addr_i  = a;
      wdata_i = d;
      @(posedge clk_i);
      #1;
      cs_i    = 1'b0;
      we_i    = 1'b0;
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk_i);
      @(negedge clk_i);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] d;
      reset_i = 1'b1;
      cs_i    = 1'b0;
      we_i    = 1'b0;
      addr_i  = '0;
      wdata_i = '0;
      GPIO_i  = 8'h03;

      // Reset state with pins already high.
      edges(2);
      check("rst_gpio_o", 32'(GPIO_o), 32'h00);
      check("rst_irq", 32'(irq_o), 32'h0);
      rd(5'h00, d); check("rst_data_in", d, 32'h00);
      reset_i = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         edges(1);
         rd(5'h00, d); check($sformatf("rel_data_in_e%0d", k), d, 32'h00);
      end
      edges(1);
      rd(5'h00, d); check("rel_data_in_e6", d, 32'h03);
      rd(5'h18, d); check("rel_status", d, 32'h00);
      check("rel_irq", 32'(irq_o), 32'h0);

      // Output write, set and clear.
      wr(5'h04, 32'h0000_00A5); check("out_write", 32'(GPIO_o), 32'hA5);
      wr(5'h08, 32'h0000_000A); check("out_set", 32'(GPIO_o), 32'hAF);
      wr(5'h0C, 32'h0000_0081); check("out_clr", 32'(GPIO_o), 32'h2E);
      rd(5'h08, d); check("rd_out_set", d, 32'h0);
      rd(5'h0C, d); check("rd_out_clr", d, 32'h0);
      rd(5'h04, d); check("rd_data_out", d, 32'h2E);

      // Settle inputs low (no enables, no capture), then reject a short glitch.
      @(negedge clk_i); GPIO_i = 8'h00;
      edges(10);
      rd(5'h00, d); check("settle_low", d, 32'h00);
      rd(5'h18, d); check("settle_status", d, 32'h00);
      wr(5'h10, 32'h01);
      rd(5'h10, d); check("rise_en", d, 32'h01);
      @(negedge clk_i); GPIO_i = 8'h01;
      edges(3);
      GPIO_i = 8'h00;
      edges(10);
      rd(5'h00, d); check("glitch_data_in", d, 32'h00);
      rd(5'h18, d); check("glitch_status", d, 32'h00);
      check("glitch_irq", 32'(irq_o), 32'h0);

      // Held rising edge on bit 0.
      GPIO_i = 8'h01;
      edges(5);
      check("rise_irq_e5", 32'(irq_o), 32'h0);
      edges(1);
      check("rise_irq_e6", 32'(irq_o), 32'h1);
      rd(5'h18, d); check("rise_status", d, 32'h01);
      rd(5'h00, d); check("rise_data_in", d, 32'h01);
      edges(4);
      check("rise_irq_hold", 32'(irq_o), 32'h1);

      // W1C colliding with a falling edge: the edge wins.
      wr(5'h14, 32'h01);
      @(negedge clk_i); GPIO_i = 8'h00;
      edges(5);
      wr(5'h18, 32'h01);
      @(negedge clk_i);
      rd(5'h18, d); check("collide_status", d, 32'h01);
      check("collide_irq", 32'(irq_o), 32'h1);
      rd(5'h00, d); check("collide_data_in", d, 32'h00);
      wr(5'h18, 32'h01);
      rd(5'h18, d); check("w1c_status", d, 32'h00);
      check("w1c_irq", 32'(irq_o), 32'h0);

      // Deselected and unmapped accesses.
      cs_i = 1'b0; we_i = 1'b1; addr_i = 5'h04; wdata_i = 32'hFF;
      #1;
      check("cs0_rdata", rdata_o, 32'h0);
      @(posedge clk_i); #1;
      we_i = 1'b0;
      check("cs0_no_write", 32'(GPIO_o), 32'h2E);
      wr(5'h1C, 32'hFF);
      rd(5'h1C, d); check("unmapped_rd", d, 32'h0);
      rd(5'h04, d); check("unmapped_out", d, 32'h2E);
      rd(5'h10, d); check("unmapped_rise", d, 32'h01);
      rd(5'h14, d); check("unmapped_fall", d, 32'h01);
      rd(5'h18, d); check("unmapped_status", d, 32'h00);

      // Asynchronous reset mid-debounce.
      wr(5'h10, 32'h81);
      @(negedge clk_i); GPIO_i = 8'h80;
      edges(6);
      rd(5'h18, d); check("pre_rst_status", d, 32'h80);
      wr(5'h04, 32'hFF);
      check("pre_rst_gpio_o", 32'(GPIO_o), 32'hFF);
      @(negedge clk_i); GPIO_i = 8'h81;
      edges(3);
      reset_i = 1'b1;
      #1;
      check("async_gpio_o", 32'(GPIO_o), 32'h00);
      check("async_irq", 32'(irq_o), 32'h0);
      rd(5'h18, d); check("async_status", d, 32'h00);
      rd(5'h00, d); check("async_data_in", d, 32'h00);
      rd(5'h10, d); check("async_rise_en", d, 32'h00);

      edges(1);
      reset_i = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
